// File: rtl/ipv4_parser.sv
// IPv4 header parser: extracts header fields, validates version/IHL/checksum,
// and re-times the beat stream by one cycle so L4 readiness lines up with it.
module ipv4_parser #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [$clog2(DATA_WIDTH/8+1)-1:0]     idx_in,
    input  logic                                  last_flag_in,
    input  logic [DATA_WIDTH-1:0]                 tdata_in,
    input  logic                                  data_valid_in,
    input  logic                                  eth_parser_ready,
    input  logic [15:0]                           ethertype,
    input  logic [4:0]                            wcnt_eth,
    output logic [$clog2(DATA_WIDTH/8+1)-1:0]     idx_out,
    output logic                                  last_flag_out,
    output logic [DATA_WIDTH-1:0]                 tdata_out,
    output logic                                  data_valid_out,
    output logic                                  ipv4_parser_ready,
    output logic [4:0]                            wcnt_ipv4,
    output logic [7:0]                            protocol,
    output logic [3:0]                            ip_ihl,
    output logic [15:0]                           ip_total_length,
    output logic [7:0]                            ip_ttl,
    output logic [31:0]                           ip_src_addr,
    output logic [31:0]                           ip_dst_addr,
    output logic                                  ip_checksum_ok,
    output logic                                  header_error
);
    localparam int unsigned LANES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

    state_t      state, state_n;
    logic [5:0]  bc, bc_n;
    logic [15:0] acc, acc_n;
    logic [7:0]  proto_sh, proto_sh_n;
    logic        eth_hold, eth_hold_n;
    logic        ready_n, cks_ok_n, herr_n;
    logic [4:0]  wcnt_n;
    logic [7:0]  protocol_n, ttl_n;
    logic [3:0]  ihl_n;
    logic [15:0] tl_n;
    logic [31:0] src_n, dst_n;

    // Next-state, header byte walk and field/checksum update
    always_comb begin : next_logic
        logic              parse;
        logic [4:0]        lo;
        logic [5:0]        bc_v;
        logic [15:0]       acc_v;
        logic [3:0]        ihl_v;
        logic [7:0]        b;
        logic [16:0]       sum17;
        logic              done;
        logic              err;
        int unsigned       k;

        state_n    = state;
        bc_n       = bc;
        acc_n      = acc;
        proto_sh_n = proto_sh;
        eth_hold_n = data_valid_in ? (eth_parser_ready && !last_flag_in) : eth_hold;
        ready_n    = ipv4_parser_ready;
        wcnt_n     = wcnt_ipv4;
        herr_n     = 1'b0;
        cks_ok_n   = ip_checksum_ok;
        protocol_n = protocol;
        ihl_n      = ip_ihl;
        tl_n       = ip_total_length;
        ttl_n      = ip_ttl;
        src_n      = ip_src_addr;
        dst_n      = ip_dst_addr;
        parse      = 1'b0;
        lo         = 5'd0;
        bc_v       = bc;
        acc_v      = acc;
        ihl_v      = ip_ihl;
        b          = 8'd0;
        sum17      = 17'd0;
        done       = 1'b0;
        err        = 1'b0;
        k          = 0;

        case (state)
            IDLE: begin
                ready_n = 1'b0;
                wcnt_n  = 5'd0;
                // Only a fresh rise of eth_parser_ready starts a frame
                if (data_valid_in && eth_parser_ready && !eth_hold) begin
                    if (ethertype != 16'h0800) begin
                        protocol_n = 8'd0;
                        state_n    = last_flag_in ? IDLE : DROP;
                    end else begin
                        parse = 1'b1;
                        lo    = wcnt_eth;
                        bc_v  = 6'd0;
                        acc_v = 16'd0;
                    end
                end
            end
            HDR: begin
                if (data_valid_in) parse = 1'b1;
            end
            PAYLOAD: begin
                ready_n = 1'b1;
                wcnt_n  = 5'd0;
                if (data_valid_in && last_flag_in) state_n = IDLE;
            end
            DROP: begin
                ready_n = 1'b0;
                wcnt_n  = 5'd0;
                if (data_valid_in && last_flag_in) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (parse) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (i >= 32'(lo) && i < 32'(idx_in) && !done && !err) begin
                    b     = tdata_in[i*8 +: 8];
                    sum17 = {1'b0, acc_v} + (bc_v[0] ? {9'd0, b} : {1'b0, b, 8'd0});
                    acc_v = sum17[15:0] + {15'd0, sum17[16]};
                    case (bc_v)
                        6'd0: begin
                            ihl_v      = b[3:0];
                            ihl_n      = b[3:0];
                            protocol_n = 8'd0;
                            cks_ok_n   = 1'b0;
                            if (b[7:4] != 4'd4 || b[3:0] < 4'd5) err = 1'b1;
                        end
                        6'd2:  tl_n[15:8]   = b;
                        6'd3:  tl_n[7:0]    = b;
                        6'd8:  ttl_n        = b;
                        6'd9:  proto_sh_n   = b;
                        6'd12: src_n[31:24] = b;
                        6'd13: src_n[23:16] = b;
                        6'd14: src_n[15:8]  = b;
                        6'd15: src_n[7:0]   = b;
                        6'd16: dst_n[31:24] = b;
                        6'd17: dst_n[23:16] = b;
                        6'd18: dst_n[15:8]  = b;
                        6'd19: dst_n[7:0]   = b;
                        default: ;
                    endcase
                    if (!err && 6'(bc_v + 6'd1) == {ihl_v, 2'b00}) begin
                        done = 1'b1;
                        k    = i;
                    end
                    bc_v = 6'(bc_v + 6'd1);
                end
            end
            bc_n  = bc_v;
            acc_n = acc_v;
            if (err) begin
                herr_n     = 1'b1;
                protocol_n = 8'd0;
                state_n    = last_flag_in ? IDLE : DROP;
            end else if (done) begin
                protocol_n = proto_sh_n;
                cks_ok_n   = (acc_v == 16'hFFFF);
                state_n    = last_flag_in ? IDLE : PAYLOAD;
                // L4 starts inside this beat, or at lane 0 of the next one
                if (k + 1 < 32'(idx_in)) begin
                    ready_n = 1'b1;
                    wcnt_n  = 5'(k + 1);
                end else begin
                    ready_n = last_flag_in;
                    wcnt_n  = 5'd0;
                end
            end else if (last_flag_in) begin
                herr_n     = 1'b1;
                protocol_n = 8'd0;
                state_n    = IDLE;
            end else begin
                state_n = HDR;
            end
        end
    end

    // State, header tracking and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            bc                <= 6'd0;
            acc               <= 16'd0;
            proto_sh          <= 8'd0;
            eth_hold          <= 1'b1;
            idx_out           <= '0;
            last_flag_out     <= 1'b0;
            tdata_out         <= '0;
            data_valid_out    <= 1'b0;
            ipv4_parser_ready <= 1'b0;
            wcnt_ipv4         <= 5'd0;
            protocol          <= 8'd0;
            ip_ihl            <= 4'd0;
            ip_total_length   <= 16'd0;
            ip_ttl            <= 8'd0;
            ip_src_addr       <= 32'd0;
            ip_dst_addr       <= 32'd0;
            ip_checksum_ok    <= 1'b0;
            header_error      <= 1'b0;
        end else begin
            state             <= state_n;
            bc                <= bc_n;
            acc               <= acc_n;
            proto_sh          <= proto_sh_n;
            eth_hold          <= eth_hold_n;
            idx_out           <= idx_in;
            last_flag_out     <= last_flag_in;
            tdata_out         <= tdata_in;
            data_valid_out    <= data_valid_in;
            ipv4_parser_ready <= ready_n;
            wcnt_ipv4         <= wcnt_n;
            protocol          <= protocol_n;
            ip_ihl            <= ihl_n;
            ip_total_length   <= tl_n;
            ip_ttl            <= ttl_n;
            ip_src_addr       <= src_n;
            ip_dst_addr       <= dst_n;
            ip_checksum_ok    <= cks_ok_n;
            header_error      <= herr_n;
        end
    end
endmodule
